al_accel_lut_acc: RTL and testbench



---
 rtl/al_accel_pkg.sv | 16 +
 rtl/al_accel_lut_acc_if.sv | 40 ++++
 rtl/al_accel_lut_sel.sv | 12 +
 rtl/al_accel_lut_acc.sv | 133 +++++++++++++
 tb/tb_al_accel_lut_acc.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/al_accel_pkg.sv
// Shared types and constants for the accelerator LUT readers.
package al_accel_pkg;

  localparam int AL_LUT_IDX_W   = 3;
  localparam int AL_LUT_ENTRIES = 8;
  localparam int AL_LUT_W       = 32;
  localparam int AL_WBITS_DEF   = 7;
  localparam int AL_ACC_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } al_state_e;

endpackage

// File: rtl/al_accel_lut_acc_if.sv
// Control, weight, LUT and result signals of the LUT reader/accumulator.
interface al_accel_lut_acc_if
  import al_accel_pkg::*;
#(
  parameter int WBITS = AL_WBITS_DEF,
  parameter int ACC_W = AL_ACC_W_DEF
);
  logic                       enb;
  logic                       start;
  logic                       acc_clr;
  logic [WBITS-1:0]           w_mag_0;
  logic [WBITS-1:0]           w_mag_1;
  logic [WBITS-1:0]           w_mag_2;
  logic signed [AL_LUT_W-1:0] lut_do_0;
  logic signed [AL_LUT_W-1:0] lut_do_1;
  logic signed [AL_LUT_W-1:0] lut_do_2;
  logic signed [AL_LUT_W-1:0] lut_do_3;
  logic signed [AL_LUT_W-1:0] lut_do_4;
  logic signed [AL_LUT_W-1:0] lut_do_5;
  logic signed [AL_LUT_W-1:0] lut_do_6;
  logic signed [AL_LUT_W-1:0] lut_do_7;
  logic                       busy;
  logic                       done;
  logic signed [ACC_W-1:0]    acc_out;

  modport master (
    output enb, start, acc_clr, w_mag_0, w_mag_1, w_mag_2,
    output lut_do_0, lut_do_1, lut_do_2, lut_do_3,
    output lut_do_4, lut_do_5, lut_do_6, lut_do_7,
    input  busy, done, acc_out
  );

  modport slave (
    input  enb, start, acc_clr, w_mag_0, w_mag_1, w_mag_2,
    input  lut_do_0, lut_do_1, lut_do_2, lut_do_3,
    input  lut_do_4, lut_do_5, lut_do_6, lut_do_7,
    output busy, done, acc_out
  );

endinterface

// File: rtl/al_accel_lut_sel.sv
// Combinational 8:1 LUT entry selector, shared by the LUT readers.
module al_accel_lut_sel
  import al_accel_pkg::*;
(
  input  logic signed [AL_LUT_W-1:0]     lut_i [AL_LUT_ENTRIES],
  input  logic        [AL_LUT_IDX_W-1:0] idx_i,
  output logic signed [AL_LUT_W-1:0]     entry_o
);

  assign entry_o = lut_i[idx_i];

endmodule

// File: rtl/al_accel_lut_acc.sv
// Bit-serial LUT reader and shift-add accumulator.
// Optional zero-skip early termination: AL_ACCEL_LUT_ACC_ZSKIP_EN.
module al_accel_lut_acc
  import al_accel_pkg::*;
#(
  parameter int WBITS = AL_WBITS_DEF,
  parameter int ACC_W = AL_ACC_W_DEF
)(
  input logic               clk,
  input logic               resetn,
  al_accel_lut_acc_if.slave bus
);

  localparam int BC_W = (WBITS > 1) ? $clog2(WBITS) : 1;

  al_state_e               state_q, state_d;
  logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WBITS-1:0]        wq0_q, wq0_d;
  logic [WBITS-1:0]        wq1_q, wq1_d;
  logic [WBITS-1:0]        wq2_q, wq2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [AL_LUT_W-1:0] lut [AL_LUT_ENTRIES];
  logic [AL_LUT_IDX_W-1:0]    idx;
  logic signed [AL_LUT_W-1:0] entry;
  logic signed [ACC_W-1:0]    entry_ext;
  logic signed [ACC_W-1:0]    addend;
  logic                       last_bit;

  assign lut[0] = bus.lut_do_0;
  assign lut[1] = bus.lut_do_1;
  assign lut[2] = bus.lut_do_2;
  assign lut[3] = bus.lut_do_3;
  assign lut[4] = bus.lut_do_4;
  assign lut[5] = bus.lut_do_5;
  assign lut[6] = bus.lut_do_6;
  assign lut[7] = bus.lut_do_7;

  assign idx = {wq2_q[bit_cnt_q], wq1_q[bit_cnt_q], wq0_q[bit_cnt_q]};

  al_accel_lut_sel u_sel (
    .lut_i   (lut),
    .idx_i   (idx),
    .entry_o (entry)
  );

  // Sign-extend to the accumulator width before shifting; high bits fall off.
  assign entry_ext = ACC_W'(entry);
  assign addend    = entry_ext <<< bit_cnt_q;
  assign last_bit  = (bit_cnt_q == BC_W'(WBITS - 1));

`ifdef AL_ACCEL_LUT_ACC_ZSKIP_EN
  logic [WBITS-1:0] wor_bits;
  logic [WBITS-1:0] mask_here;
  logic [WBITS-1:0] mask_next;
  logic             rem_here;
  logic             rem_next;

  // rem_next lets RUN leave right after the highest set bit instead of
  // spending one more cycle discovering the remaining bits are zero.
  always_comb begin
    wor_bits  = wq0_q | wq1_q | wq2_q;
    mask_here = '1;
    mask_here = mask_here << bit_cnt_q;
    mask_next = mask_here << 1;
    rem_here  = |(wor_bits & mask_here);
    rem_next  = |(wor_bits & mask_next);
  end
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wq0_d     = wq0_q;
    wq1_d     = wq1_q;
    wq2_d     = wq2_q;
    acc_d     = acc_q;
    if (bus.enb) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d   = ST_RUN;
            bit_cnt_d = '0;
            wq0_d     = bus.w_mag_0;
            wq1_d     = bus.w_mag_1;
            wq2_d     = bus.w_mag_2;
            if (bus.acc_clr) acc_d = '0;
          end
        end
        ST_RUN: begin
`ifdef AL_ACCEL_LUT_ACC_ZSKIP_EN
          if (!rem_here) begin
            state_d = ST_DONE;
          end else begin
            acc_d     = acc_q + addend;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit || !rem_next) state_d = ST_DONE;
          end
`else
          acc_d     = acc_q + addend;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) state_d = ST_DONE;
`endif
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      wq0_q     <= '0;
      wq1_q     <= '0;
      wq2_q     <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wq0_q     <= wq0_d;
      wq1_q     <= wq1_d;
      wq2_q     <= wq2_d;
      acc_q     <= acc_d;
    end
  end

  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.acc_out = acc_q;

endmodule

// File: tb/tb_al_accel_lut_acc.sv
// Scoreboard bench for al_accel_lut_acc (honours AL_ACCEL_LUT_ACC_ZSKIP_EN).
module tb_al_accel_lut_acc;

  localparam int WBITS = 7;
  localparam int ACC_W = 32;
  localparam int LIMIT = 60;

  typedef struct {
    logic signed [ACC_W-1:0] acc;
    int                      lat;
  } exp_t;

  logic clk;
  logic resetn;
  logic signed [31:0] lut_tb [8];
  logic signed [ACC_W-1:0] model_acc;
  exp_t sb_q [$];
  int checks;
  int failures;

  al_accel_lut_acc_if #(.WBITS(WBITS), .ACC_W(ACC_W)) bus ();

  al_accel_lut_acc #(.WBITS(WBITS), .ACC_W(ACC_W)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.lut_do_0 = lut_tb[0];
  assign bus.lut_do_1 = lut_tb[1];
  assign bus.lut_do_2 = lut_tb[2];
  assign bus.lut_do_3 = lut_tb[3];
  assign bus.lut_do_4 = lut_tb[4];
  assign bus.lut_do_5 = lut_tb[5];
  assign bus.lut_do_6 = lut_tb[6];
  assign bus.lut_do_7 = lut_tb[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic signed [ACC_W-1:0] model_run(
    input logic signed [ACC_W-1:0] base,
    input logic [WBITS-1:0] w0, input logic [WBITS-1:0] w1, input logic [WBITS-1:0] w2);
    logic signed [ACC_W-1:0] a;
    logic [2:0] k;
    a = base;
    for (int b = 0; b < WBITS; b++) begin
      k = {w2[b], w1[b], w0[b]};
      a = a + (ACC_W'(lut_tb[k]) <<< b);
    end
    return a;
  endfunction

  function automatic int model_lat(
    input logic [WBITS-1:0] w0, input logic [WBITS-1:0] w1, input logic [WBITS-1:0] w2);
`ifdef AL_ACCEL_LUT_ACC_ZSKIP_EN
    logic [WBITS-1:0] o;
    int h;
    o = w0 | w1 | w2;
    h = -1;
    for (int b = 0; b < WBITS; b++) if (o[b]) h = b;
    return (h < 0) ? 2 : h + 2;
`else
    return WBITS + 1;
`endif
  endfunction

  // mode 1: enb low for three edges early in RUN, with a start pulse inside.
  task automatic run_op(input logic [WBITS-1:0] w0, input logic [WBITS-1:0] w1,
                        input logic [WBITS-1:0] w2, input logic clr, input int mode,
                        input string tag);
    exp_t e;
    int n;
    logic got;
    e.acc = model_run(clr ? '0 : model_acc, w0, w1, w2);
    e.lat = model_lat(w0, w1, w2) + ((mode == 1) ? 3 : 0);
    model_acc = e.acc;
    sb_q.push_back(e);
    bus.w_mag_0 = w0;
    bus.w_mag_1 = w1;
    bus.w_mag_2 = w2;
    bus.acc_clr = clr;
    bus.start   = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < LIMIT && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (n == 1) begin
          bus.start   = (mode == 1);
          bus.w_mag_0 = ~w0;
          bus.w_mag_1 = ~w1;
          bus.w_mag_2 = ~w2;
          if (mode == 1) bus.enb = 1'b0;
        end
        if (mode == 1 && n == 2) begin
          check_eq({tag, "_busy_stall"}, bus.busy, 1);
          bus.start = 1'b0;
        end
        if (mode == 1 && n == 4) bus.enb = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.enb   = 1'b1;
    if (!got) begin
      check_eq({tag, "_timeout"}, n, e.lat);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_acc"}, bus.acc_out, e.acc);
      check_eq({tag, "_lat"}, n, e.lat);
      @(posedge clk);
      #1;
      check_eq({tag, "_idle"}, {bus.busy, bus.done}, 0);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_acc = '0;
    lut_tb    = '{0, 3, 5, 8, -2, 1, 3, 6};
    resetn      = 1'b0;
    bus.enb     = 1'b1;
    bus.start   = 1'b0;
    bus.acc_clr = 1'b0;
    bus.w_mag_0 = '0;
    bus.w_mag_1 = '0;
    bus.w_mag_2 = '0;
    #12;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_acc", bus.acc_out, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run_op(7'd2, 7'd3, 7'd1, 1'b1, 0, "base");
    run_op(7'd2, 7'd3, 7'd1, 1'b0, 0, "cont");
    run_op(7'd0, 7'd0, 7'd0, 1'b1, 0, "zero");
    run_op(7'd127, 7'd127, 7'd127, 1'b1, 0, "max_pos");
    lut_tb[7] = -6;
    run_op(7'd127, 7'd127, 7'd127, 1'b1, 0, "max_neg");
    lut_tb[7] = 6;
    run_op(7'd2, 7'd3, 7'd1, 1'b1, 1, "stall");

    // Asynchronous reset in the middle of a run.
    bus.w_mag_0 = 7'd2;
    bus.w_mag_1 = 7'd3;
    bus.w_mag_2 = 7'd1;
    bus.acc_clr = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_done", bus.done, 0);
    check_eq("arst_acc", bus.acc_out, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_acc = '0;
    @(posedge clk);
    #1;
    run_op(7'd2, 7'd3, 7'd1, 1'b1, 0, "post_rst");
    run_op(7'd1, 7'd1, 7'd1, 1'b1, 0, "ones");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
